// File: rtl/fifo_rr_drain_sched_pkg.sv
// Shared types and defaults for the round-robin FIFO drain scheduler.
// Contents: FSM state encoding and the default parameter values used by
// the scheduler top, its picker and its bus interface.
package fifo_sched_pkg;

  localparam int BUS_WIDTH_DEF = 8;
  localparam int NUM_SRC_DEF   = 4;
  localparam int BURST_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    OUT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fifo_rr_drain_sched_if.sv
// Bus bundle between the drain scheduler, its source FIFOs and the consumer.
// master: scheduler side (drives FIFO_RD_EN, OUT_DATA/OUT_SRC/OUT_VALID, BUSY).
// slave : environment side (drives FIFO_EMPTY, FIFO_DATA, SRC_MASK, OUT_READY).
interface fifo_rr_drain_sched_if
  import fifo_sched_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int NUM_SRC   = NUM_SRC_DEF
);

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]           FIFO_EMPTY;
  logic [NUM_SRC*BUS_WIDTH-1:0] FIFO_DATA;
  logic [NUM_SRC-1:0]           FIFO_RD_EN;
  logic [NUM_SRC-1:0]           SRC_MASK;
  logic [BUS_WIDTH-1:0]         OUT_DATA;
  logic [SRC_W-1:0]             OUT_SRC;
  logic                         OUT_VALID;
  logic                         OUT_READY;
  logic                         BUSY;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA, SRC_MASK, OUT_READY,
    output FIFO_RD_EN, OUT_DATA, OUT_SRC, OUT_VALID, BUSY
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA, SRC_MASK, OUT_READY,
    input  FIFO_RD_EN, OUT_DATA, OUT_SRC, OUT_VALID, BUSY
  );

endinterface

// File: rtl/fifo_rr_drain_sched_picker.sv
// Round-robin picker: first eligible source at or after ptr_i, wrapping.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: eligible_i/ptr_i in; grant_o (valid only when any_elig_o) out.
module fifo_rr_picker
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEF,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [SRC_W-1:0]   grant_o,
  output logic               any_elig_o
);

  assign any_elig_o = |eligible_i;

  // Scan from the farthest offset down to offset 0 so the nearest eligible
  // source (lowest offset from ptr) is the one left in grant_o.
  always_comb begin
    grant_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_i) + k) % NUM_SRC;
      if (eligible_i[idx]) begin
        grant_o = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain_sched.sv
// Round-robin drain of NUM_SRC registered-output FIFOs into one valid/ready stream.
// Latency: RD_EN in cycle t -> OUT_VALID from t+2; up to BURST words per grant.
// Backpressure: OUT held while !OUT_READY and no RD_EN is issued until the handshake.
// Ports: CLK, RSTn (async, active-low); bus (master modport) carries FIFO and output signals.
module fifo_rr_drain_sched
  import fifo_sched_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int BURST     = BURST_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  fifo_rr_drain_sched_if.master  bus
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(BURST + 1);

  sched_state_t         state_q;
  logic [SRC_W-1:0]     ptr_q;
  logic [SRC_W-1:0]     src_q;
  logic [CNT_W-1:0]     burst_cnt_q;
  logic [BUS_WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0]     out_src_q;
  logic                 out_valid_q;

  logic [NUM_SRC-1:0]   eligible;
  logic [SRC_W-1:0]     grant;
  logic                 any_elig;
  logic                 hs;
  logic                 burst_more;
  logic [SRC_W-1:0]     ptr_d;
  logic [CNT_W-1:0]     burst_cnt_d;
  logic [NUM_SRC-1:0]   rd_en;

  assign eligible = ~bus.FIFO_EMPTY & bus.SRC_MASK;

  fifo_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .any_elig_o (any_elig)
  );

  // OUT_VALID is always set in OUT, so the handshake only needs the state.
  assign hs          = (state_q == OUT) && bus.OUT_READY;
  assign burst_more  = (burst_cnt_q < CNT_W'(BURST)) && eligible[src_q];
  assign ptr_d       = (src_q == SRC_W'(NUM_SRC - 1)) ? '0 : src_q + 1'b1;
  assign burst_cnt_d = burst_cnt_q + 1'b1;

  // The read strobe is combinational from state, so it is gated with RSTn to
  // drop immediately when reset asserts while a source is still eligible.
  always_comb begin
    rd_en = '0;
    if (RSTn) begin
      case (state_q)
        IDLE:    if (any_elig)         rd_en[grant] = 1'b1;
        OUT:     if (hs && burst_more) rd_en[src_q] = 1'b1;
        default: rd_en = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      src_q       <= '0;
      burst_cnt_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            src_q       <= grant;
            burst_cnt_q <= CNT_W'(1);
            state_q     <= CAP;
          end
        end
        CAP: begin
          // FIFO DATA_OUT is registered: the word popped last cycle is on the bus now.
          out_data_q  <= bus.FIFO_DATA[src_q*BUS_WIDTH +: BUS_WIDTH];
          out_src_q   <= src_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (burst_more) begin
              burst_cnt_q <= burst_cnt_d;
              state_q     <= CAP;
            end else begin
              ptr_q   <= ptr_d;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.FIFO_RD_EN = rd_en;
  assign bus.OUT_DATA   = out_data_q;
  assign bus.OUT_SRC    = out_src_q;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.BUSY       = (state_q != IDLE);

endmodule
